// File: rtl/uart_tx_if.sv
// uart_tx_if: signal bundle between a word source and the UART transmitter.
// Carries the baud tick, parity mode, the parallel word handshake and the
// transmitter's status/serial outputs. clk and reset stay outside as plain ports.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  bclk;
    logic [1:0]            parity;
    logic [DATA_WIDTH-1:0] p_data_in;
    logic                  data_valid;
    logic                  ready;
    logic                  s_data_out;
    logic                  busy;
    logic                  tx_done;

    // Word source side: offers words and the shared baud tick, watches status.
    modport master (
        output bclk,
        output parity,
        output p_data_in,
        output data_valid,
        input  ready,
        input  s_data_out,
        input  busy,
        input  tx_done
    );

    // Transmitter side: consumes words, drives the serial line and status.
    modport slave (
        input  bclk,
        input  parity,
        input  p_data_in,
        input  data_valid,
        output ready,
        output s_data_out,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
// Takes a parallel word through a valid/ready handshake and shifts it out LSB
// first as: start bit, DATA_WIDTH data bits, optional parity bit, stop bit(s).
// Bit timing is derived from the shared bclk tick (SAMPLING ticks per bit), so
// the transmitter and the oversampling receiver run from one baud generator.
// Optional feature: define UART_TX_TWO_STOP_EN to send two stop bits per frame;
// with it undefined a single stop bit is sent and no second-stop state exists.
module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int SAMPLING   = 16
) (
    input logic      clk,
    input logic      reset,
    uart_tx_if.slave txIf
);

    localparam int TICK_W = (SAMPLING > 1) ? $clog2(SAMPLING) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLING - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q,     state_d;
    logic [TICK_W-1:0]     tickCnt_q,   tickCnt_d;
    logic [BIT_W-1:0]      bitCnt_q,    bitCnt_d;
    logic [DATA_WIDTH-1:0] shiftReg_q,  shiftReg_d;
    logic                  parityEn_q,  parityEn_d;
    logic                  parityBit_q, parityBit_d;
    logic                  line_q,      line_d;
    logic                  done_q,      done_d;
`ifdef UART_TX_TWO_STOP_EN
    logic                  secondStop_q, secondStop_d;
`endif

    logic accept;
    logic bitEnd;

    // A word is taken whenever the source offers one while we sit idle; a bit
    // period closes on the SAMPLING-th bclk tick counted inside that bit.
    assign accept = txIf.data_valid && (state_q == IDLE);
    assign bitEnd = txIf.bclk && (tickCnt_q == TICK_LAST);

    assign txIf.ready      = (state_q == IDLE);
    assign txIf.busy       = (state_q != IDLE);
    assign txIf.s_data_out = line_q;
    assign txIf.tx_done    = done_q;

    // Next-state logic: sequences the frame and decides the line level for the
    // next bit, so the registered line only moves on the edge a new bit starts.
    always_comb begin
        state_d     = state_q;
        tickCnt_d   = tickCnt_q;
        bitCnt_d    = bitCnt_q;
        shiftReg_d  = shiftReg_q;
        parityEn_d  = parityEn_q;
        parityBit_d = parityBit_q;
        line_d      = line_q;
        done_d      = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        secondStop_d = secondStop_q;
`endif

        if ((state_q != IDLE) && txIf.bclk) begin
            if (bitEnd) begin
                tickCnt_d = '0;
            end else begin
                tickCnt_d = tickCnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (accept) begin
                    state_d     = START;
                    tickCnt_d   = '0;
                    bitCnt_d    = '0;
                    shiftReg_d  = txIf.p_data_in;
                    parityEn_d  = (txIf.parity == 2'b01) || (txIf.parity == 2'b10);
                    parityBit_d = (txIf.parity == 2'b01) ? ~^txIf.p_data_in
                                                         :  ^txIf.p_data_in;
                    line_d      = 1'b0;
                end
            end

            START: begin
                if (bitEnd) begin
                    state_d  = DATA;
                    bitCnt_d = '0;
                    line_d   = shiftReg_q[0];
                end
            end

            DATA: begin
                if (bitEnd) begin
                    shiftReg_d = shiftReg_q >> 1;
                    if (bitCnt_q == BIT_LAST) begin
                        if (parityEn_q) begin
                            state_d = PARITY;
                            line_d  = parityBit_q;
                        end else begin
                            state_d = STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                        line_d   = shiftReg_q[1];
                    end
                end
            end

            PARITY: begin
                if (bitEnd) begin
                    state_d = STOP;
                    line_d  = 1'b1;
                end
            end

            STOP: begin
                line_d = 1'b1;
                if (bitEnd) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (!secondStop_q) begin
                        secondStop_d = 1'b1;
                    end else begin
                        secondStop_d = 1'b0;
                        state_d      = IDLE;
                        done_d       = 1'b1;
                    end
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end

            default: begin
                state_d   = IDLE;
                tickCnt_d = '0;
                bitCnt_d  = '0;
                line_d    = 1'b1;
            end
        endcase
    end

    // State register: reset abandons any frame, returns the line high and
    // suppresses the completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            bitCnt_q    <= '0;
            shiftReg_q  <= '0;
            parityEn_q  <= 1'b0;
            parityBit_q <= 1'b0;
            line_q      <= 1'b1;
            done_q      <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            secondStop_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tickCnt_q   <= tickCnt_d;
            bitCnt_q    <= bitCnt_d;
            shiftReg_q  <= shiftReg_d;
            parityEn_q  <= parityEn_d;
            parityBit_q <= parityBit_d;
            line_q      <= line_d;
            done_q      <= done_d;
`ifdef UART_TX_TWO_STOP_EN
            secondStop_q <= secondStop_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx (DATA_WIDTH=8, SAMPLING=16).
// Honours UART_TX_TWO_STOP_EN the same way the design does.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int DW   = 8;
    localparam int SAMP = 16;
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS  = 2;
    localparam int LEN_PLAIN  = 176;
    localparam int LEN_PARITY = 192;
    localparam int STOP_TICKS = 32;
`else
    localparam int STOP_BITS  = 1;
    localparam int LEN_PLAIN  = 160;
    localparam int LEN_PARITY = 176;
    localparam int STOP_TICKS = 16;
`endif

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    int bclkPeriod  = 1;
    int bclkPhase   = 0;
    int holdRequest = 0;

    bit   mActive = 1'b0;
    bit   mDone   = 1'b0;
    int   mTicks  = 0;
    logic mFrame[$];

    logic trace[$];

    uart_tx_if #(.DATA_WIDTH(DW)) txIf ();

    uart_tx #(
        .DATA_WIDTH(DW),
        .SAMPLING  (SAMP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .txIf (txIf)
    );

    // 100 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud tick source: one pulse every bclkPeriod clocks, frozen while a hold is pending.
    initial begin
        txIf.bclk = 1'b0;
        forever begin
            @(negedge clk);
            if (holdRequest > 0) begin
                txIf.bclk = 1'b0;
                holdRequest--;
            end else if (bclkPhase >= bclkPeriod - 1) begin
                bclkPhase = 0;
                txIf.bclk = 1'b1;
            end else begin
                bclkPhase++;
                txIf.bclk = 1'b0;
            end
        end
    end

    // Expected frame as a list of line levels, one entry per bit period.
    function automatic void buildFrame(input logic [DW-1:0] data, input logic [1:0] mode);
        int ones;
        ones = $countones(data);
        mFrame.delete();
        mFrame.push_back(1'b0);
        for (int i = 0; i < DW; i++) mFrame.push_back(data[i]);
        if (mode == 2'b01) mFrame.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        else if (mode == 2'b10) mFrame.push_back((ones % 2 == 1) ? 1'b1 : 1'b0);
        for (int i = 0; i < STOP_BITS; i++) mFrame.push_back(1'b1);
    endfunction

    // Model: counts bclk ticks since acceptance; the line is the frame entry for ticks/SAMP.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mActive = 1'b0;
                mDone   = 1'b0;
                mTicks  = 0;
            end else begin
                mDone = 1'b0;
                if (mActive) begin
                    if (txIf.bclk) mTicks++;
                    if (mTicks == mFrame.size() * SAMP) begin
                        mActive = 1'b0;
                        mDone   = 1'b1;
                    end
                end else if (txIf.data_valid) begin
                    buildFrame(txIf.p_data_in, txIf.parity);
                    mActive = 1'b1;
                    mTicks  = 0;
                end
            end
        end
    end

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    task automatic checkOutput();
        logic expLine;
        expLine = mActive ? mFrame[mTicks / SAMP] : 1'b1;
        checkBit("s_data_out", txIf.s_data_out, expLine);
        checkBit("ready", txIf.ready, !mActive);
        checkBit("busy", txIf.busy, mActive);
        checkBit("tx_done", txIf.tx_done, mDone);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) checkOutput();
        end
    end

    // Line samples for every cycle of a frame in progress.
    initial begin
        forever begin
            @(negedge clk);
            if (txIf.busy === 1'b1) trace.push_back(txIf.s_data_out);
        end
    end

    // Mid-bit samples of the first ten bits (bclk every clock), bit i at position i.
    function automatic logic [9:0] traceWord();
        logic [9:0] w;
        w = '0;
        for (int j = 0; j < 10; j++) begin
            if (j * SAMP + 8 < trace.size()) w[j] = trace[j * SAMP + 8];
            else w[j] = 1'bx;
        end
        return w;
    endfunction

    task automatic waitIdle();
        int n;
        n = 0;
        while (txIf.ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (txIf.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: got ready=%b, expected 1", txIf.ready);
        end
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (txIf.tx_done !== 1'b1 && cycles < 20000) begin
            @(negedge clk);
            cycles++;
        end
        if (txIf.tx_done !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got tx_done=%b, expected 1", txIf.tx_done);
        end
    endtask

    // Offer one word, drop valid after acceptance, scramble the inputs mid-frame,
    // and return the number of clocks from the accepting edge to tx_done.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic [1:0] mode, output int cycles);
        waitIdle();
        trace.delete();
        txIf.p_data_in  = data;
        txIf.parity     = mode;
        txIf.data_valid = 1'b1;
        @(negedge clk);
        txIf.data_valid = 1'b0;
        txIf.p_data_in  = DW'($urandom);
        txIf.parity     = 2'($urandom);
        waitDone(cycles);
    endtask

    initial begin
        int         cyc;
        int         cnt;
        int         runLen;
        int         maxRun;
        int         firstOneRun;
        logic [1:0] mode;
        int         parBits;

        reset           = 1'b1;
        txIf.data_valid = 1'b0;
        txIf.p_data_in  = '0;
        txIf.parity     = 2'b00;

        @(negedge clk);
        checkBit("reset_line", txIf.s_data_out, 1'b1);
        checkBit("reset_ready", txIf.ready, 1'b1);
        checkBit("reset_busy", txIf.busy, 1'b0);
        checkBit("reset_done", txIf.tx_done, 1'b0);
        @(negedge clk);
        reset   = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);

        $display("[TB] plain frame 0x55");
        applyStimulus(8'h55, 2'b00, cyc);
        checkValue("len_55", cyc, LEN_PLAIN);
        checkValue("frame_55", {22'd0, traceWord()}, 32'h2AA);
        checkBit("ready_with_done", txIf.ready, 1'b1);

        $display("[TB] parity frames 0x07");
        applyStimulus(8'h07, 2'b10, cyc);
        checkValue("len_even", cyc, LEN_PARITY);
        checkBit("parity_even", trace[9 * SAMP + 8], 1'b1);
        applyStimulus(8'h07, 2'b01, cyc);
        checkValue("len_odd", cyc, LEN_PARITY);
        checkBit("parity_odd", trace[9 * SAMP + 8], 1'b0);

        $display("[TB] held valid 0xA3 then 0x3C");
        waitIdle();
        trace.delete();
        txIf.parity     = 2'b00;
        txIf.p_data_in  = 8'hA3;
        txIf.data_valid = 1'b1;
        @(negedge clk);
        txIf.p_data_in = 8'h3C;
        waitDone(cyc);
        checkValue("len_a3", cyc, LEN_PLAIN);
        checkValue("frame_a3", {22'd0, traceWord()}, 32'h346);
        trace.delete();
        @(negedge clk);
        txIf.data_valid = 1'b0;
        checkBit("b2b_busy", txIf.busy, 1'b1);
        checkBit("b2b_start", txIf.s_data_out, 1'b0);
        waitDone(cyc);
        checkValue("frame_3c", {22'd0, traceWord()}, 32'h278);

        $display("[TB] stop length 0x81");
        applyStimulus(8'h81, 2'b00, cyc);
        checkValue("len_81", cyc, LEN_PLAIN);
        cnt = 0;
        for (int i = 9 * SAMP; i < trace.size(); i++) if (trace[i] === 1'b1) cnt++;
        checkValue("stop_ticks", cnt, STOP_TICKS);

        $display("[TB] slow bclk with freeze");
        bclkPeriod = 4;
        fork
            applyStimulus(8'h55, 2'b00, cyc);
            begin
                repeat (200) @(negedge clk);
                holdRequest = 100;
            end
        join
        runLen      = 1;
        maxRun      = 0;
        firstOneRun = -1;
        for (int i = 1; i <= trace.size(); i++) begin
            if (i < trace.size() && trace[i] === trace[i - 1]) begin
                runLen++;
            end else begin
                if (runLen > maxRun) maxRun = runLen;
                if (firstOneRun < 0 && trace[i - 1] === 1'b1) firstOneRun = runLen;
                runLen = 1;
            end
        end
        checkValue("slow_bit_len", firstOneRun, 64);
        checkValue("frozen_bit_len", maxRun, 164);
        bclkPeriod = 1;

        $display("[TB] reset during data bit 3");
        waitIdle();
        trace.delete();
        txIf.parity     = 2'b00;
        txIf.p_data_in  = 8'hFF;
        txIf.data_valid = 1'b1;
        @(negedge clk);
        txIf.data_valid = 1'b0;
        repeat (71) @(negedge clk);
        checkBit("data3_line", txIf.s_data_out, 1'b1);
        checkBit("data3_busy", txIf.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkBit("abort_line", txIf.s_data_out, 1'b1);
        checkBit("abort_ready", txIf.ready, 1'b1);
        checkBit("abort_busy", txIf.busy, 1'b0);
        checkBit("abort_done", txIf.tx_done, 1'b0);
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (txIf.tx_done === 1'b1) cnt++;
        end
        checkValue("abort_no_done", cnt, 0);
        applyStimulus(8'h00, 2'b00, cyc);
        checkValue("len_00", cyc, LEN_PLAIN);
        checkValue("frame_00", {22'd0, traceWord()}, 32'h200);

        $display("[TB] random frames");
        for (int f = 0; f < 24; f++) begin
            bclkPeriod = $urandom_range(1, 3);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            mode    = 2'($urandom);
            parBits = (mode == 2'b01 || mode == 2'b10) ? 1 : 0;
            applyStimulus(DW'($urandom), mode, cyc);
            if (bclkPeriod == 1) checkValue("rand_len", cyc, (1 + DW + parBits + STOP_BITS) * SAMP);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the UART. It is the sending end of the link whose receiver consumes s_data_in with SAMPLING-times oversampling.
- Accepts a parallel word through a valid/ready handshake and shifts it out LSB first. The frame is: start bit, DATA_WIDTH data bits, optional parity bit, stop bit.
- Timing comes from the same bclk tick that drives the receiver, so both ends share one baud generator.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).
- SAMPLING, 16, number of bclk ticks per serial bit. Must match the receiver.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bclk  input  1  baud tick, a one-clk-wide pulse at SAMPLING x baud rate in the clk domain.
- parity  input  2  parity mode: 00 none, 01 odd, 10 even, 11 none.
- p_data_in  input  DATA_WIDTH  word to transmit.
- data_valid  input  1  p_data_in is valid.
- ready  output  1  transmitter idle, can accept a word.
- s_data_out  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- tx_done  output  1  one-clk pulse when a frame completes.

Behaviour:
- Reset (synchronous, active-high), values after the first edge with reset=1:
  - s_data_out=1, ready=1, busy=0, tx_done=0.
  - State=IDLE, tick counter=0, bit counter=0, shift register=0.
- Accept:
  - Occurs on an edge where data_valid & ready.
  - At that edge: latch p_data_in into the shift register, latch parity mode, compute the parity bit (odd mode = ~^data, even mode = ^data).
  - The next state is START. ready=0 and busy=1 from the following cycle.
  - data_valid while ready=0 is ignored; there is no queuing.
- Bit timing:
  - The tick counter increments only on clk edges where bclk=1.
  - A bit ends on the edge where bclk=1 and the counter equals SAMPLING-1. On that edge the counter wraps to 0 and the state or bit advances.
  - Each bit therefore lasts exactly SAMPLING bclk ticks. If bclk stays low, everything holds.
- States:
  - IDLE: s_data_out=1. Goes to START on accept.
  - START: s_data_out=0 for one bit. Then DATA with bit counter=0.
  - DATA:
    - s_data_out = shift_reg[0]. At each bit end, shift right and increment the bit counter.
    - After bit DATA_WIDTH-1, go to PARITY if the latched mode is 01 or 10, else to STOP.
  - PARITY: s_data_out = latched parity bit for one bit. Then STOP.
  - STOP:
    - s_data_out=1 for one bit.
    - At the bit end: tx_done=1 for exactly one cycle and the state returns to IDLE.
    - ready=1 and busy=0 in that same cycle, so a new word may be accepted on the next edge. Back-to-back frames have no extra idle bits.
- s_data_out is registered and changes only on the edge that enters a new bit. There are no glitches.
- Changes to the parity input mid-frame have no effect on the current frame.
- Reset asserted mid-frame: the frame is abandoned, the line returns to 1 on that edge, and all outputs take their reset values. No tx_done pulse is generated.
- Frame length in bclk ticks: SAMPLING x (1 + DATA_WIDTH + P + S), where P=1 if parity is enabled, else 0, and S is the number of stop bits.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined: STOP lasts two bit periods (2 x SAMPLING ticks, line high). tx_done is raised at the end of the second stop bit. S=2.
- Undefined: one stop bit, S=1. No second-stop logic is synthesised.

Test Plan:
- SAMPLING=16, parity=00, send 0x55 with a bclk tick every clk.
  - Line is 0,1,0,1,0,1,0,1,0 then 1 (stop), each level held 16 clks.
  - tx_done pulses once 160 bclk ticks after accept.
  - ready rises with tx_done.
- parity=10 (even), send 0x07 → parity bit=1. parity=01 (odd), send 0x07 → parity bit=0. Frame length is 176 ticks.
- Hold data_valid=1 with 0xA3 then 0x3C across frames.
  - 0xA3 is accepted; the valid held during busy is ignored.
  - 0x3C is accepted in the cycle after tx_done.
  - The second start bit begins immediately after the first stop bit.
- bclk pulses every 4th clk: every bit lasts 64 clks. Holding bclk low for 100 clks mid-data freezes s_data_out and all counters.
- Assert reset for one cycle during DATA bit 3 of 0xFF.
  - Next cycle: s_data_out=1, ready=1, busy=0, no tx_done.
  - A following send of 0x00 transmits a correct full frame.
- With UART_TX_TWO_STOP_EN defined, parity=00, send 0x81: the stop level lasts 32 ticks and tx_done comes at tick 176.
